// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory.
// Define MEMARB_PERF_EN to add saturating completion/stall counters.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic [DATA_W-1:0] if_data_out,
    output logic              if_ready_out,
    input  logic              dm_read_in,
    input  logic              dm_write_in,
    input  logic [ADDR_W-1:0] dm_addr_in,
    input  logic [DATA_W-1:0] dm_wdata_in,
    output logic [DATA_W-1:0] dm_rdata_out,
    output logic              dm_ready_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in,
    input  logic              mem_ack_in,
`ifdef MEMARB_PERF_EN
    output logic [31:0]       perf_if_cnt_out,
    output logic [31:0]       perf_dm_cnt_out,
    output logic [31:0]       perf_stall_cnt_out,
`endif
    output logic              stall_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    state_t            state, state_nx;
    logic              owner, owner_nx;
    logic [3:0]        streak, streak_nx;
    logic              req_nx, we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx, if_data_nx, dm_data_nx;
    logic              if_rdy_nx, dm_rdy_nx;
    logic              dm_req, dm_win;

    assign dm_req = dm_read_in | dm_write_in;
    // DM keeps priority until it has starved a waiting IF too long
    assign dm_win = ~if_req_in || (MAX_DM_STREAK == 0) || (streak < STREAK_MAX);

    assign stall_out = (if_req_in & ~if_ready_out) | (dm_req & ~dm_ready_out);

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        streak_nx  = streak;
        req_nx     = mem_req_out;
        we_nx      = mem_we_out;
        addr_nx    = mem_addr_out;
        wdata_nx   = mem_wdata_out;
        if_data_nx = if_data_out;
        dm_data_nx = dm_rdata_out;
        if_rdy_nx  = 1'b0;
        dm_rdy_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_req && dm_win) begin
                    state_nx = ACCESS;
                    owner_nx = 1'b1;
                    req_nx   = 1'b1;
                    we_nx    = dm_write_in;
                    addr_nx  = dm_addr_in;
                    wdata_nx = dm_wdata_in;
                    if (if_req_in && streak != 4'd15)
                        streak_nx = streak + 4'd1;
                end else if (if_req_in) begin
                    state_nx  = ACCESS;
                    owner_nx  = 1'b0;
                    req_nx    = 1'b1;
                    we_nx     = 1'b0;
                    addr_nx   = if_addr_in;
                    wdata_nx  = '0;
                    streak_nx = 4'd0;
                end
            end
            ACCESS: begin
                if (mem_ack_in) begin
                    state_nx = RESP;
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    if (!owner) begin
                        if_data_nx = mem_rdata_in;
                        if_rdy_nx  = 1'b1;
                    end else begin
                        if (!mem_we_out)
                            dm_data_nx = mem_rdata_in;
                        dm_rdy_nx = 1'b1;
                    end
                end
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state         <= IDLE;
            owner         <= 1'b0;
            streak        <= 4'd0;
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            if_data_out   <= '0;
            dm_rdata_out  <= '0;
            if_ready_out  <= 1'b0;
            dm_ready_out  <= 1'b0;
        end else begin
            state         <= state_nx;
            owner         <= owner_nx;
            streak        <= streak_nx;
            mem_req_out   <= req_nx;
            mem_we_out    <= we_nx;
            mem_addr_out  <= addr_nx;
            mem_wdata_out <= wdata_nx;
            if_data_out   <= if_data_nx;
            dm_rdata_out  <= dm_data_nx;
            if_ready_out  <= if_rdy_nx;
            dm_ready_out  <= dm_rdy_nx;
        end
    end

`ifdef MEMARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset_in) begin
            perf_if_cnt_out    <= '0;
            perf_dm_cnt_out    <= '0;
            perf_stall_cnt_out <= '0;
        end else begin
            if (if_ready_out && perf_if_cnt_out != '1)
                perf_if_cnt_out <= perf_if_cnt_out + 32'd1;
            if (dm_ready_out && perf_dm_cnt_out != '1)
                perf_dm_cnt_out <= perf_dm_cnt_out + 32'd1;
            if (stall_out && perf_stall_cnt_out != '1)
                perf_stall_cnt_out <= perf_stall_cnt_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_DM_STREAK = 2).
// Inputs change on the falling edge; outputs are checked there too.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = '0;
    logic [31:0] if_data_out;
    logic        if_ready_out;
    logic        dm_read_in = 1'b0;
    logic        dm_write_in = 1'b0;
    logic [31:0] dm_addr_in = '0;
    logic [31:0] dm_wdata_in = '0;
    logic [31:0] dm_rdata_out;
    logic        dm_ready_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in = '0;
    logic        mem_ack_in = 1'b0;
    logic        stall_out;
`ifdef MEMARB_PERF_EN
    logic [31:0] perf_if_cnt_out;
    logic [31:0] perf_dm_cnt_out;
    logic [31:0] perf_stall_cnt_out;
    int          stall_tally = 0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DM_STREAK(2)
    ) dut (
        .clk(clk),
        .reset_in(reset_in),
        .if_req_in(if_req_in),
        .if_addr_in(if_addr_in),
        .if_data_out(if_data_out),
        .if_ready_out(if_ready_out),
        .dm_read_in(dm_read_in),
        .dm_write_in(dm_write_in),
        .dm_addr_in(dm_addr_in),
        .dm_wdata_in(dm_wdata_in),
        .dm_rdata_out(dm_rdata_out),
        .dm_ready_out(dm_ready_out),
        .mem_req_out(mem_req_out),
        .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in(mem_rdata_in),
        .mem_ack_in(mem_ack_in),
`ifdef MEMARB_PERF_EN
        .perf_if_cnt_out(perf_if_cnt_out),
        .perf_dm_cnt_out(perf_dm_cnt_out),
        .perf_stall_cnt_out(perf_stall_cnt_out),
`endif
        .stall_out(stall_out)
    );

`ifdef MEMARB_PERF_EN
    always @(posedge clk) begin
        if (reset_in) stall_tally = 0;
        else if (stall_out) stall_tally = stall_tally + 1;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] order [6];
        order = '{32'h400, 32'h400, 32'h300, 32'h400, 32'h400, 32'h300};

        step(); step();
        chk("rst_req", 32'(mem_req_out), 32'd0);
        chk("rst_we", 32'(mem_we_out), 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);
        chk("rst_ifrdy", 32'(if_ready_out), 32'd0);
        chk("rst_dmrdy", 32'(dm_ready_out), 32'd0);
        chk("rst_ifdata", if_data_out, 32'd0);
        chk("rst_dmdata", dm_rdata_out, 32'd0);
        reset_in = 1'b0;

        // ack with no access in flight must do nothing
        mem_ack_in = 1'b1;
        step();
        mem_ack_in = 1'b0;
        chk("stray_req", 32'(mem_req_out), 32'd0);
        chk("stray_rdy", 32'(if_ready_out | dm_ready_out), 32'd0);

        // IF-only read, zero-wait memory
        if_req_in = 1'b1;
        if_addr_in = 32'h0000_0010;
        #1 chk("if_stall_c0", 32'(stall_out), 32'd1);
        step();
        chk("if_req_c1", 32'(mem_req_out), 32'd1);
        chk("if_addr_c1", mem_addr_out, 32'h10);
        chk("if_we_c1", 32'(mem_we_out), 32'd0);
        chk("if_rdy_c1", 32'(if_ready_out), 32'd0);
        mem_ack_in = 1'b1;
        mem_rdata_in = 32'h2002_0005;
        step();
        mem_ack_in = 1'b0;
        chk("if_rdy_c2", 32'(if_ready_out), 32'd1);
        chk("if_data_c2", if_data_out, 32'h2002_0005);
        chk("if_req_c2", 32'(mem_req_out), 32'd0);
        chk("if_stall_c2", 32'(stall_out), 32'd0);
        if_req_in = 1'b0;
        step();
        chk("if_rdy_c3", 32'(if_ready_out), 32'd0);
        chk("if_stall_c3", 32'(stall_out), 32'd0);

        // DM write, ack three cycles after the request is raised
        dm_write_in = 1'b1;
        dm_addr_in = 32'h40;
        dm_wdata_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wr_req", 32'(mem_req_out), 32'd1);
            chk("wr_we", 32'(mem_we_out), 32'd1);
            chk("wr_addr", mem_addr_out, 32'h40);
            chk("wr_wdata", mem_wdata_out, 32'hDEAD_BEEF);
            chk("wr_rdy_early", 32'(dm_ready_out), 32'd0);
            chk("wr_stall", 32'(stall_out), 32'd1);
            if (i == 3) begin
                mem_ack_in = 1'b1;
                mem_rdata_in = 32'h1234_5678;
            end
        end
        step();
        mem_ack_in = 1'b0;
        chk("wr_rdy", 32'(dm_ready_out), 32'd1);
        chk("wr_rdata_keep", dm_rdata_out, 32'd0);
        chk("wr_req_drop", 32'(mem_req_out), 32'd0);
        chk("wr_ifdata_keep", if_data_out, 32'h2002_0005);
        dm_write_in = 1'b0;
        step();
        chk("wr_rdy_once", 32'(dm_ready_out), 32'd0);

        // simultaneous IF and DM: DM first, then IF
        if_req_in = 1'b1;
        if_addr_in = 32'h100;
        dm_read_in = 1'b1;
        dm_addr_in = 32'h200;
        step();
        chk("both_first", mem_addr_out, 32'h200);
        chk("both_we", 32'(mem_we_out), 32'd0);
        mem_ack_in = 1'b1;
        mem_rdata_in = 32'hAAAA_0001;
        step();
        mem_ack_in = 1'b0;
        chk("both_dmrdy", 32'(dm_ready_out), 32'd1);
        chk("both_dmdata", dm_rdata_out, 32'hAAAA_0001);
        chk("both_ifrdy0", 32'(if_ready_out), 32'd0);
        chk("both_stall", 32'(stall_out), 32'd1);
        dm_read_in = 1'b0;
        step();
        step();
        chk("both_second", mem_addr_out, 32'h100);
        chk("both_req2", 32'(mem_req_out), 32'd1);
        mem_ack_in = 1'b1;
        mem_rdata_in = 32'hBBBB_0002;
        step();
        mem_ack_in = 1'b0;
        chk("both_ifrdy", 32'(if_ready_out), 32'd1);
        chk("both_ifdata", if_data_out, 32'hBBBB_0002);
        chk("both_dmkeep", dm_rdata_out, 32'hAAAA_0001);
        if_req_in = 1'b0;
        step();

        // IF held, DM re-requesting: streak guard forces IF every third grant
        if_req_in = 1'b1;
        if_addr_in = 32'h300;
        dm_read_in = 1'b1;
        dm_addr_in = 32'h400;
        for (int g = 0; g < 6; g++) begin
            step();
            chk($sformatf("order_%0d", g), mem_addr_out, order[g]);
            mem_ack_in = 1'b1;
            mem_rdata_in = 32'hC000_0000 + 32'(g);
            step();
            mem_ack_in = 1'b0;
            chk($sformatf("order_rdy_%0d", g),
                32'({if_ready_out, dm_ready_out}),
                (order[g] == 32'h300) ? 32'd2 : 32'd1);
            step();
        end
        if_req_in = 1'b0;
        dm_read_in = 1'b0;
        chk("order_ifdata", if_data_out, 32'hC000_0005);
        chk("order_dmdata", dm_rdata_out, 32'hC000_0004);
        step();

`ifdef MEMARB_PERF_EN
        chk("perf_if", perf_if_cnt_out, 32'd4);
        chk("perf_dm", perf_dm_cnt_out, 32'd6);
        chk("perf_stall", perf_stall_cnt_out, 32'(stall_tally));
`endif

        // reset during ACCESS, ack arrives the cycle after reset
        if_req_in = 1'b1;
        if_addr_in = 32'h500;
        step();
        chk("rma_req", 32'(mem_req_out), 32'd1);
        chk("rma_addr", mem_addr_out, 32'h500);
        reset_in = 1'b1;
        step();
        chk("rma_req0", 32'(mem_req_out), 32'd0);
        chk("rma_addr0", mem_addr_out, 32'd0);
        chk("rma_ifdata0", if_data_out, 32'd0);
        chk("rma_dmdata0", dm_rdata_out, 32'd0);
        reset_in = 1'b0;
        if_req_in = 1'b0;
        mem_ack_in = 1'b1;
        mem_rdata_in = 32'hFFFF_FFFF;
        step();
        mem_ack_in = 1'b0;
        chk("rma_ifrdy", 32'(if_ready_out), 32'd0);
        chk("rma_ifdata", if_data_out, 32'd0);
        chk("rma_req_late", 32'(mem_req_out), 32'd0);
        step();
        chk("rma_idle", 32'({mem_req_out, if_ready_out, dm_ready_out}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single unified memory port between the pipeline's instruction-fetch requester (IF) and data-memory requester (DM, MEM stage).
- Sequences each access through a request/acknowledge handshake to a variable-latency memory.
- Returns read data to the requester and drives a pipeline stall while any access is outstanding.
- Sits between the PC/IF-ID stage, the EX/MEM stage, and the shared memory.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is waiting before IF is forced; 0 disables the guard (strict DM priority); legal range 0–15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_in  in  1  synchronous, active-high reset.
- if_req_in  in  1  IF read request; level, held until if_ready_out.
- if_addr_in  in  ADDR_W  IF address; stable while if_req_in is high.
- if_data_out  out  DATA_W  fetched word.
- if_ready_out  out  1  one-cycle completion pulse to IF.
- dm_read_in  in  1  DM read request; level.
- dm_write_in  in  1  DM write request; level.
- dm_addr_in  in  ADDR_W  DM address.
- dm_wdata_in  in  DATA_W  DM write data.
- dm_rdata_out  out  DATA_W  DM read data.
- dm_ready_out  out  1  one-cycle completion pulse to DM.
- mem_req_out  out  1  memory request; held until ack.
- mem_we_out  out  1  1 = write.
- mem_addr_out  out  ADDR_W  memory address.
- mem_wdata_out  out  DATA_W  memory write data.
- mem_rdata_in  in  DATA_W  memory read data; valid in the mem_ack_in cycle.
- mem_ack_in  in  1  one-cycle completion from memory.
- stall_out  out  1  pipeline freeze (drives PC write and IF/ID write enables low).

Behaviour:
- Reset values: all outputs 0, state IDLE, streak counter 0, owner flag 0.
- State IDLE:
  - DM request = dm_read_in | dm_write_in.
  - If a DM request is pending and (IF is idle, or streak < MAX_DM_STREAK, or MAX_DM_STREAK == 0): grant DM, go to ACCESS.
  - Else if if_req_in is high: grant IF, go to ACCESS.
  - Else stay in IDLE.
- Grant (registered): mem_req_out=1; mem_addr_out, mem_wdata_out and mem_we_out latched from the winner.
  - mem_we_out = dm_write_in for DM grants; 0 for IF grants.
  - dm_read_in and dm_write_in both high is treated as a write.
- State ACCESS: hold mem_* stable. On mem_ack_in:
  - mem_req_out drops next cycle.
  - For reads, mem_rdata_in is latched into the owner's data output.
  - Go to RESP.
- State RESP: owner's ready pulses high for exactly this cycle; requests are not sampled; next state IDLE.
  - Requester must drop or replace its request by the following cycle.
- Data outputs hold their last value until overwritten by the next read completion for that port. DM writes leave dm_rdata_out unchanged.
- Latency: request in cycle 0 with 0-cycle memory (ack in cycle 1) gives ready in cycle 2 and the next grant in cycle 3. Minimum 3 cycles per access.
- Streak counter: increments, saturating at 15, on a DM grant while if_req_in is high; clears on any IF grant.
- stall_out (combinational) = (if_req_in & ~if_ready_out) | (dm request & ~dm_ready_out).
- mem_ack_in outside ACCESS is ignored.
- Reset mid-access: immediate return to IDLE next edge; mem_req_out=0; a late ack is ignored; no ready pulse is issued.

Optional Feature:
- Macro: MEMARB_PERF_EN.
- Defined: adds outputs perf_if_cnt_out, perf_dm_cnt_out and perf_stall_cnt_out (32 bits each, saturating, cleared by reset_in).
  - perf_if_cnt_out counts completed IF accesses (if_ready_out pulses).
  - perf_dm_cnt_out counts completed DM accesses (dm_ready_out pulses).
  - perf_stall_cnt_out counts cycles with stall_out=1.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- IF-only read, addr 0x0000_0010, memory acks 0 cycles after request with 0x2002_0005 → mem_req_out high cycle 1, if_ready_out pulse cycle 2, if_data_out=0x2002_0005, stall_out low from cycle 2.
- DM write addr 0x40 data 0xDEAD_BEEF, ack after 3 cycles → mem_we_out=1, mem_wdata_out=0xDEAD_BEEF held 4 cycles, single dm_ready_out pulse, dm_rdata_out unchanged.
- IF and DM requesting in the same cycle, MAX_DM_STREAK=4 → DM served first, IF served next.
- IF held and DM re-requesting continuously, MAX_DM_STREAK=2 → grant order DM, DM, IF, DM, DM, IF.
- reset_in asserted during ACCESS, ack arriving 1 cycle after reset → no ready pulse, mem_req_out=0, state IDLE, outputs 0.
- MEMARB_PERF_EN defined, 3 IF reads and 2 DM reads → perf_if_cnt_out=3, perf_dm_cnt_out=2, perf_stall_cnt_out equals the count of stall_out-high cycles.
